adc_capture_ctrl: RTL and testbench

Capture sequencer for the RF ADC capture path, in the `rf_clk` domain. It sits between the six ADC AXI-Stream inputs and the per-stream 32-bit capture FIFOs, and gates stream valids into those FIFOs for exactly one programmed capture length. Capture starts on a software start or, optionally, a level trigger on stream 0. The block then waits for the DDR write side to report drain before raising completion, and records overflow and stream-alignment errors for software.

---
 rtl/adc_capture_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: gates ADC stream valids into the capture FIFOs for one
// programmed capture length, then waits for DDR drain before signalling done.
// Ports: rf_clk/rf_rst (async, active-high); cap_start/cap_abort/cap_beats
// control; trig_mode/trig_level/trig_sample level trigger on stream 0;
// s_tvalid/s_tready from ADC; fifo_tvalid/fifo_tready to capture FIFOs;
// drain_done from DMA; busy/armed/cap_done/overflow/align_err/cfg_err,
// beat_cnt and state for software.
// Optional macro ADC_CAP_LEVEL_TRIG_EN builds the ARMED state and the level
// trigger; without it every start goes straight to CAPTURE.
module adc_capture_ctrl #(
  parameter int NUM_STREAMS = 6,
  parameter int CNT_W       = 32
) (
  input  logic                   rf_clk,
  input  logic                   rf_rst,
  input  logic                   cap_start,
  input  logic                   cap_abort,
  input  logic [CNT_W-1:0]       cap_beats,
  input  logic                   trig_mode,
  input  logic [7:0]             trig_level,
  input  logic [7:0]             trig_sample,
  input  logic [NUM_STREAMS-1:0] s_tvalid,
  output logic [NUM_STREAMS-1:0] s_tready,
  output logic [NUM_STREAMS-1:0] fifo_tvalid,
  input  logic [NUM_STREAMS-1:0] fifo_tready,
  input  logic                   drain_done,
  output logic                   busy,
  output logic                   armed,
  output logic                   cap_done,
  output logic                   overflow,
  output logic                   align_err,
  output logic                   cfg_err,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q;
  logic             gate_q;
  logic             done_q;
  logic             ovf_q;
  logic             align_q;
  logic             cfg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] len_q;

  logic all_v;
  logic any_v;
  logic counted;
  logic last_beat;
  logic ovf_hit;
  logic misalign;
  logic start_ok;
  logic start_zero;
  logic go_armed;
  logic trig_hit;

  assign s_tready    = '1;
  assign fifo_tvalid = s_tvalid & {NUM_STREAMS{gate_q}};

  assign all_v     = &s_tvalid;
  assign any_v     = |s_tvalid;
  assign counted   = gate_q & all_v;
  assign cnt_d     = cnt_q + CNT_W'(1);
  assign last_beat = (cnt_q == len_q - CNT_W'(1));
  assign ovf_hit   = |(fifo_tvalid & ~fifo_tready);
  assign misalign  = gate_q & any_v & ~all_v;

  // An abort in the same cycle suppresses the start entirely.
  assign start_ok   = cap_start & ~cap_abort & (cap_beats != '0);
  assign start_zero = cap_start & ~cap_abort & (cap_beats == '0);

`ifdef ADC_CAP_LEVEL_TRIG_EN
  logic signed [7:0] prev_q;

  assign go_armed = trig_mode;
  // Rising crossing: previous stream-0 sample below, current at/above level.
  assign trig_hit = s_tvalid[0]
                  & (prev_q < $signed(trig_level))
                  & ($signed(trig_sample) >= $signed(trig_level));
  assign armed    = (state_q == S_ARMED);

  always_ff @(posedge rf_clk or posedge rf_rst) begin
    if (rf_rst) begin
      prev_q <= -8'sd128;
    end else if (state_q == S_IDLE) begin
      prev_q <= -8'sd128;
    end else if (state_q == S_ARMED && s_tvalid[0]) begin
      prev_q <= $signed(trig_sample);
    end
  end
`else
  logic unused_trig;

  assign unused_trig = ^{trig_mode, trig_level, trig_sample};
  assign go_armed    = 1'b0;
  assign trig_hit    = 1'b0;
  assign armed       = 1'b0;
`endif

  assign busy      = (state_q != S_IDLE);
  assign cap_done  = done_q;
  assign overflow  = ovf_q;
  assign align_err = align_q;
  assign cfg_err   = cfg_q;
  assign beat_cnt  = cnt_q;
  assign state     = state_q;

  always_ff @(posedge rf_clk or posedge rf_rst) begin
    if (rf_rst) begin
      state_q <= S_IDLE;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      align_q <= 1'b0;
      cfg_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      ovf_q   <= ovf_q | ovf_hit;
      align_q <= align_q | misalign;
      unique case (state_q)
        S_IDLE: begin
          if (start_zero) begin
            cfg_q <= 1'b1;
          end else if (start_ok) begin
            len_q   <= cap_beats;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            align_q <= 1'b0;
            cfg_q   <= 1'b0;
            if (go_armed) begin
              state_q <= S_ARMED;
            end else begin
              state_q <= S_CAPTURE;
              gate_q  <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (cap_abort) begin
            state_q <= S_IDLE;
          end else if (trig_hit) begin
            state_q <= S_CAPTURE;
            gate_q  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (cap_abort) begin
            state_q <= S_IDLE;
            gate_q  <= 1'b0;
          end else if (counted) begin
            cnt_q <= cnt_d;
            if (last_beat) begin
              state_q <= S_DRAIN;
              gate_q  <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (cap_abort) begin
            state_q <= S_IDLE;
          end else if (drain_done) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          gate_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed self-checking bench for adc_capture_ctrl.
// Drives inputs 1ns after rising edges and checks outputs before the next edge.
module tb_adc_capture_ctrl;

  logic        rf_clk = 1'b0;
  logic        rf_rst;
  logic        cap_start;
  logic        cap_abort;
  logic [31:0] cap_beats;
  logic        trig_mode;
  logic [7:0]  trig_level;
  logic [7:0]  trig_sample;
  logic [5:0]  s_tvalid;
  logic [5:0]  s_tready;
  logic [5:0]  fifo_tvalid;
  logic [5:0]  fifo_tready;
  logic        drain_done;
  logic        busy;
  logic        armed;
  logic        cap_done;
  logic        overflow;
  logic        align_err;
  logic        cfg_err;
  logic [31:0] beat_cnt;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  adc_capture_ctrl dut (
    .rf_clk      (rf_clk),
    .rf_rst      (rf_rst),
    .cap_start   (cap_start),
    .cap_abort   (cap_abort),
    .cap_beats   (cap_beats),
    .trig_mode   (trig_mode),
    .trig_level  (trig_level),
    .trig_sample (trig_sample),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .fifo_tvalid (fifo_tvalid),
    .fifo_tready (fifo_tready),
    .drain_done  (drain_done),
    .busy        (busy),
    .armed       (armed),
    .cap_done    (cap_done),
    .overflow    (overflow),
    .align_err   (align_err),
    .cfg_err     (cfg_err),
    .beat_cnt    (beat_cnt),
    .state       (state)
  );

  always #5 rf_clk = ~rf_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rf_clk);
    #1;
  endtask

  task automatic start(input logic [31:0] n, input logic mode);
    cap_beats = n;
    trig_mode = mode;
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
  endtask

  initial begin
    rf_rst      = 1'b1;
    cap_start   = 1'b0;
    cap_abort   = 1'b0;
    cap_beats   = 32'd0;
    trig_mode   = 1'b0;
    trig_level  = 8'd0;
    trig_sample = 8'd0;
    s_tvalid    = 6'h3F;
    fifo_tready = 6'h3F;
    drain_done  = 1'b0;
    #12;
    chk("rst_tready", {26'd0, s_tready}, 32'h3F);
    chk("rst_fifo_tvalid", {26'd0, fifo_tvalid}, 32'h0);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_beat_cnt", beat_cnt, 32'd0);
    rf_rst = 1'b0;
    tick();

    // Immediate capture of 16 beats
    chk("pre_start_gate", {26'd0, fifo_tvalid}, 32'h0);
    start(32'd16, 1'b0);
    chk("imm_state_cap", {29'd0, state}, 32'd2);
    chk("imm_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("imm_gate_%0d", i), {26'd0, fifo_tvalid}, 32'h3F);
      tick();
    end
    #1;
    chk("imm_gate_closed", {26'd0, fifo_tvalid}, 32'h0);
    chk("imm_beat_cnt", beat_cnt, 32'd16);
    chk("imm_state_drain", {29'd0, state}, 32'd3);
    tick();
    chk("drain_hold", {29'd0, state}, 32'd3);
    drain_done = 1'b1;
    tick();
    drain_done = 1'b0;
    chk("done_pulse", {31'd0, cap_done}, 32'd1);
    chk("done_state", {29'd0, state}, 32'd4);
    tick();
    chk("done_pulse_end", {31'd0, cap_done}, 32'd0);
    chk("idle_after_done", {29'd0, state}, 32'd0);

`ifdef ADC_CAP_LEVEL_TRIG_EN
    // Level trigger: crossing on 25 with level 20
    trig_level = 8'd20;
    s_tvalid   = 6'h3F;
    trig_sample = 8'hFB;
    start(32'd4, 1'b1);
    chk("trig_armed_state", {29'd0, state}, 32'd1);
    chk("trig_armed", {31'd0, armed}, 32'd1);
    tick();
    chk("trig_after_m5", {29'd0, state}, 32'd1);
    trig_sample = 8'd10;
    tick();
    chk("trig_after_10", {29'd0, state}, 32'd1);
    trig_sample = 8'd25;
    #1;
    chk("trig_cross_not_gated", {26'd0, fifo_tvalid}, 32'h0);
    tick();
    chk("trig_fired", {29'd0, state}, 32'd2);
    chk("trig_armed_low", {31'd0, armed}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("trig_gate_%0d", i), {26'd0, fifo_tvalid}, 32'h3F);
      tick();
    end
    chk("trig_beat_cnt", beat_cnt, 32'd4);
    chk("trig_drain", {29'd0, state}, 32'd3);
    cap_abort = 1'b1;
    tick();
    cap_abort = 1'b0;
    chk("trig_abort_idle", {29'd0, state}, 32'd0);
    chk("trig_abort_nodone", {31'd0, cap_done}, 32'd0);
`else
    // Without the trigger build, trig_mode is ignored
    start(32'd2, 1'b1);
    chk("notrig_state", {29'd0, state}, 32'd2);
    chk("notrig_armed", {31'd0, armed}, 32'd0);
    tick();
    tick();
    chk("notrig_beat_cnt", beat_cnt, 32'd2);
    chk("notrig_drain", {29'd0, state}, 32'd3);
    cap_abort = 1'b1;
    tick();
    cap_abort = 1'b0;
    chk("notrig_abort_idle", {29'd0, state}, 32'd0);
    chk("notrig_abort_nodone", {31'd0, cap_done}, 32'd0);
`endif

    // Alignment and overflow errors
    start(32'd10, 1'b0);
    s_tvalid = 6'h3E;
    #1;
    chk("align_passed", {26'd0, fifo_tvalid}, 32'h3E);
    tick();
    chk("align_err", {31'd0, align_err}, 32'd1);
    chk("align_not_counted", beat_cnt, 32'd0);
    s_tvalid    = 6'h3F;
    fifo_tready = 6'h37;
    tick();
    fifo_tready = 6'h3F;
    chk("overflow", {31'd0, overflow}, 32'd1);
    chk("ovf_counted", beat_cnt, 32'd1);
    cap_abort = 1'b1;
    tick();
    cap_abort = 1'b0;

    // Abort at beat 7 of 100
    start(32'd100, 1'b0);
    chk("abort_errs_cleared", {30'd0, overflow, align_err}, 32'd0);
    repeat (7) tick();
    chk("abort_pre_cnt", beat_cnt, 32'd7);
    cap_abort = 1'b1;
    tick();
    cap_abort = 1'b0;
    chk("abort_idle", {29'd0, state}, 32'd0);
    chk("abort_gate", {26'd0, fifo_tvalid}, 32'h0);
    chk("abort_cnt_hold", beat_cnt, 32'd7);
    chk("abort_nodone", {31'd0, cap_done}, 32'd0);

    // Configuration errors
    start(32'd0, 1'b0);
    chk("cfg_err", {31'd0, cfg_err}, 32'd1);
    chk("cfg_stay_idle", {29'd0, state}, 32'd0);
    cap_abort = 1'b1;
    start(32'd5, 1'b0);
    cap_abort = 1'b0;
    chk("start_abort_idle", {29'd0, state}, 32'd0);
    chk("start_abort_cfg", {31'd0, cfg_err}, 32'd1);
    chk("start_abort_cnt", beat_cnt, 32'd7);

    // Async reset in DRAIN
    start(32'd3, 1'b0);
    chk("cfg_err_cleared", {31'd0, cfg_err}, 32'd0);
    s_tvalid = 6'h3E;
    tick();
    s_tvalid = 6'h3F;
    repeat (3) tick();
    chk("pre_rst_drain", {29'd0, state}, 32'd3);
    chk("pre_rst_align", {31'd0, align_err}, 32'd1);
    #2;
    rf_rst = 1'b1;
    #1;
    chk("arst_state", {29'd0, state}, 32'd0);
    chk("arst_tready", {26'd0, s_tready}, 32'h3F);
    chk("arst_beat_cnt", beat_cnt, 32'd0);
    chk("arst_flags",
        {26'd0, busy, armed, cap_done, overflow, align_err, cfg_err},
        32'd0);
    chk("arst_gate", {26'd0, fifo_tvalid}, 32'h0);
    tick();
    rf_rst = 1'b0;
    tick();
    start(32'd2, 1'b0);
    chk("post_rst_cap", {29'd0, state}, 32'd2);
    tick();
    tick();
    chk("post_rst_cnt", beat_cnt, 32'd2);
    chk("post_rst_drain", {29'd0, state}, 32'd3);
    drain_done = 1'b1;
    tick();
    drain_done = 1'b0;
    chk("post_rst_done", {31'd0, cap_done}, 32'd1);
    tick();
    chk("post_rst_idle", {29'd0, state}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
